// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM states, bubble word, opcode constants
// used by the control unit, and the IF/ID payload.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // 32-bit modulo increment; 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats stall, stall beats load; an unstalled
// cycle with nothing to load inserts a bubble. Bubbles keep the old PC fields.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    load,
  input  fetch_stage_pkg::if_id_t load_data,
  output fetch_stage_pkg::if_id_t if_id
);
  import fetch_stage_pkg::*;

  if_id_t if_id_d, if_id_q;

  // Next IF/ID contents by flush > stall > load > bubble priority.
  always_comb begin
    if_id_d = if_id_q;
    if (flush || (!stall && !load)) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (!stall) begin
      if_id_d = load_data;
    end
  end

  // IF/ID state; resets to a bubble at PC 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc       <= '0;
      if_id_q.pc_plus4 <= '0;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-outstanding-request imem handshake, a one-word skid
// buffer for responses that arrive under stall, and redirect handling that
// drops the in-flight response of a squashed request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [6:0]  opD,
  output logic [2:0]  functD
);
  import fetch_stage_pkg::*;

  fetch_state_e state_d, state_q;
  logic [31:0]  pcf_d, pcf_q;
  logic [31:0]  skid_d, skid_q;
  logic         imem_req_d, imem_req_q;
  logic         ld;
  if_id_t       ld_data, if_id;

  // Next-state, PC and skid decisions; a redirect always wins the PC.
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    skid_d  = skid_q;
    ld      = 1'b0;
    ld_data = '{instr: imem_rdata, pc: pcf_q, pc_plus4: pc_inc(pcf_q), valid: 1'b1};
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (BranchTakenE) begin
          pcf_d = BranchTargetE;
          // Without a response this cycle the old request is still in flight.
          state_d = imem_valid ? S_REQ : S_DISCARD;
        end else if (imem_valid) begin
          if (StallF) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            ld    = 1'b1;
            pcf_d = pc_inc(pcf_q);
          end
        end
      end
      S_HOLD: begin
        if (BranchTakenE) begin
          pcf_d   = BranchTargetE;
          skid_d  = '0;
          state_d = S_REQ;
        end else if (!StallF) begin
          ld            = 1'b1;
          ld_data.instr = skid_q;
          pcf_d         = pc_inc(pcf_q);
          skid_d        = '0;
          state_d       = S_REQ;
        end
      end
      S_DISCARD: begin
        // Squashed response is swallowed here; a new redirect still steers PCF.
        if (BranchTakenE) pcf_d = BranchTargetE;
        if (imem_valid)   state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
    imem_req_d = (state_d == S_REQ);
  end

  // Fetch FSM state with registered request output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pcf_q      <= RESET_PC;
      skid_q     <= '0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      skid_q     <= skid_d;
      imem_req_q <= imem_req_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (StallF),
    .flush     (FlushD),
    .load      (ld),
    .load_data (ld_data),
    .if_id     (if_id)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = pcf_q;
  assign InstrD    = if_id.instr;
  assign PCD       = if_id.pc;
  assign PCPlus4D  = if_id.pc_plus4;
  assign ValidD    = if_id.valid;
  assign opD       = if_id.instr[6:0];
  assign functD    = if_id.instr[14:12];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model plus per-cycle compare,
// directed scenarios with literal expectations, then a random-control soak.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        StallF = 1'b0, FlushD = 1'b0, BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  opD;
  logic [2:0]  functD;

  int checks = 0, errors = 0;

  // memory model
  bit          mem_busy = 0;
  int          mem_cnt = 0, lat = 1;
  logic [31:0] mem_addr = '0;
  logic [31:0] cap_q[$];

  // fetch model: PC, pending squashed response, buffered word, IF/ID contents
  bit          m_boot = 1, m_drop = 0, m_skid_full = 0, m_vld = 0;
  logic [31:0] m_skid_w = '0, m_pc = RST_PC, m_instr = NOP, m_pcd = '0, m_pc4 = '0;
  bit          watch_stale = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .opD(opD), .functD(functD)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[24:0], 7'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_drop = 0; m_skid_full = 0; m_skid_w = '0; m_pc = RST_PC;
    m_instr = NOP; m_pcd = '0; m_pc4 = '0; m_vld = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented this cycle.
  task automatic model_step();
    bit ld;
    logic [31:0] lw, lp;
    ld = 0; lw = '0; lp = '0;
    if (!rst_n) begin model_reset(); return; end
    if (m_boot) begin
      m_boot = 0;
    end else if (m_drop) begin
      if (imem_valid) m_drop = 0;
      if (BranchTakenE) m_pc = BranchTargetE;
    end else if (m_skid_full) begin
      if (BranchTakenE) begin
        m_skid_full = 0; m_pc = BranchTargetE;
      end else if (!StallF) begin
        ld = 1; lw = m_skid_w; lp = m_pc; m_pc = m_pc + 32'd4; m_skid_full = 0;
      end
    end else begin
      if (BranchTakenE) begin
        m_pc = BranchTargetE; m_drop = !imem_valid;
      end else if (imem_valid) begin
        if (StallF) begin m_skid_full = 1; m_skid_w = imem_rdata; end
        else begin ld = 1; lw = imem_rdata; lp = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
    if (FlushD) begin
      m_instr = NOP; m_vld = 0;
    end else if (StallF) begin
    end else if (ld) begin
      m_instr = lw; m_pcd = lp; m_pc4 = lp + 32'd4; m_vld = 1;
    end else begin
      m_instr = NOP; m_vld = 0;
    end
  endtask

  // One-outstanding-request memory with programmable latency.
  task automatic mem_tick();
    bit was_busy;
    if (!rst_n) begin
      mem_busy = 0; imem_valid = 0; imem_rdata = 32'hDEAD_BEEF; return;
    end
    was_busy = mem_busy;
    imem_valid = 0; imem_rdata = 32'hDEAD_BEEF;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1; imem_rdata = instr_of(mem_addr); mem_busy = 0;
      end
    end
    if (!was_busy && imem_req) begin
      mem_busy = 1; mem_addr = imem_addr; mem_cnt = lat; cap_q.push_back(imem_addr);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
    mem_tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!imem_valid && n < 20) begin cyc(); n++; end
    if (!imem_valid) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for imem_valid", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    if (!imem_req) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for imem_req", name);
    end
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_boot && !m_drop && !m_skid_full});
      chk("imem_addr", imem_addr, m_pc);
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_pc4);
      chk("ValidD", {31'b0, ValidD}, {31'b0, m_vld});
      chk("opD", {25'b0, opD}, {25'b0, m_instr[6:0]});
      chk("functD", {29'b0, functD}, {29'b0, m_instr[14:12]});
      if (ValidD) chk("instr_matches_pc", InstrD, instr_of(PCD));
      if (watch_stale) chk("stale_word_absent", {31'b0, InstrD == 32'h0000_0833}, 32'd0);
    end
  end

  initial begin
    // reset values
    repeat (3) cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'd0);
    rst_n = 1'b1;
    cap_q.delete();

    // sequential fetch, latency 1
    for (int k = 0; k < 3; k++) begin
      wait_valid("seq");
      cyc();
      chk("seq_valid", {31'b0, ValidD}, 32'd1);
      chk("seq_pcd", PCD, k * 4);
    end
    chk("seq_instr2", InstrD, 32'h0000_0433);
    if (cap_q.size() >= 3) begin
      chk("seq_addr0", cap_q[0], 32'h0);
      chk("seq_addr1", cap_q[1], 32'h4);
      chk("seq_addr2", cap_q[2], 32'h8);
    end else begin
      checks++; errors++;
      $display("FAIL seq_addrs: got %0d requests expected 3", cap_q.size());
    end

    // stall on the response cycle, held three cycles
    wait_valid("stall");
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_addr", imem_addr, 32'h0000_000C);
      chk("hold_instr", InstrD, 32'h0000_0013);
    end
    StallF = 1'b0;
    lat = 3;
    cyc();
    chk("skid_instr", InstrD, 32'h0000_0633);
    chk("skid_pcd", PCD, 32'h0000_000C);
    chk("skid_addr", imem_addr, 32'h0000_0010);

    // redirect while a latency-3 request is in flight
    BranchTakenE = 1'b1; BranchTargetE = 32'h0000_0100;
    watch_stale = 1;
    cyc();
    BranchTakenE = 1'b0;
    chk("disc_req", {31'b0, imem_req}, 32'd0);
    chk("disc_addr", imem_addr, 32'h0000_0100);
    wait_req("redirect");
    chk("redir_addr", imem_addr, 32'h0000_0100);
    wait_valid("redirect");
    cyc();
    watch_stale = 0;
    chk("redir_instr", InstrD, 32'h0000_8033);
    chk("redir_pcd", PCD, 32'h0000_0100);

    // stall holds a valid IF/ID, then flush beats stall
    StallF = 1'b1; lat = 1;
    wait_valid("flush");
    chk("stall_keep", InstrD, 32'h0000_8033);
    FlushD = 1'b1;
    cyc();
    chk("flush_instr", InstrD, 32'h0000_0013);
    chk("flush_valid", {31'b0, ValidD}, 32'd0);
    chk("flush_pcd", PCD, 32'h0000_0100);
    FlushD = 1'b0; StallF = 1'b0;
    cyc();
    chk("flush_skid", InstrD, 32'h0000_8233);
    chk("flush_skid_pcd", PCD, 32'h0000_0104);

    // fetch at the top of the address space wraps
    BranchTakenE = 1'b1; BranchTargetE = 32'hFFFF_FFFC;
    cyc();
    BranchTakenE = 1'b0;
    wait_req("wrap");
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap");
    cyc();
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_instr", InstrD, 32'hFFFF_FE33);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // reset while a request is outstanding
    wait_valid("prerst");
    cyc();
    #1;
    chk("prerst_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_instr", InstrD, 32'h0000_0013);
    chk("arst_pcd", PCD, 32'h0);
    chk("arst_pc4", PCPlus4D, 32'h0);
    chk("arst_valid", {31'b0, ValidD}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cap_q.delete();
    chk("boot_req", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("boot_done_req", {31'b0, imem_req}, 32'd1);
    chk("boot_done_addr", imem_addr, 32'h0);
    wait_valid("postrst");
    cyc();
    chk("postrst_instr", InstrD, 32'h0000_0033);
    chk("postrst_pcd", PCD, 32'h0);
    chk("postrst_first_req", cap_q.size() > 0 ? cap_q[0] : 32'hFFFF_FFFF, 32'h0);

    // random control soak, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      StallF        = ($urandom_range(0, 3) == 0);
      FlushD        = ($urandom_range(0, 7) == 0);
      BranchTakenE  = ($urandom_range(0, 9) == 0);
      BranchTargetE = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      lat           = $urandom_range(1, 3);
      cyc();
    end
    StallF = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble word in IF/ID.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 StallF  input  1  hazard stall; freezes PC and IF/ID register.
REQ-006 FlushD  input  1  replaces IF/ID contents with a bubble.
REQ-007 BranchTakenE  input  1  redirect request from EXE.
REQ-008 BranchTargetE  input  32  redirect address.
REQ-009 imem_req  output  1  instruction-memory request, held until imem_valid.
REQ-010 imem_addr  output  32  request address (PCF).
REQ-011 imem_valid  input  1  response strobe, latency >=1 cycle, one outstanding request max.
REQ-012 imem_rdata  input  32  instruction word, qualified by imem_valid.
REQ-013 InstrD  output  32  registered instruction to decode.
REQ-014 PCD  output  32  PC of InstrD.
REQ-015 PCPlus4D  output  32  PCD + 4.
REQ-016 ValidD  output  1  InstrD is a real instruction, not a bubble.
REQ-017 opD  output  7  InstrD[6:0], combinational from IF/ID register.
REQ-018 functD  output  3  InstrD[14:12], combinational from IF/ID register.

Function
REQ-019 FSM states SHALL be BOOT, REQ, HOLD, DISCARD; imem_req=1 only in REQ.
REQ-020 BOOT SHALL last exactly one cycle after reset release, then go to REQ.
REQ-021 REQ, BranchTakenE=1: PCF<=BranchTargetE; next state REQ if imem_valid same cycle (word discarded), else DISCARD.
REQ-022 REQ, imem_valid=1, StallF=0: IF/ID loads {imem_rdata, PCF, PCF+4, ValidD=1}, PCF<=PCF+4, stay REQ.
REQ-023 REQ, imem_valid=1, StallF=1: word stored in skid buffer, PCF held, go HOLD.
REQ-024 REQ, imem_valid=0: PCF and imem_addr held stable, stay REQ.
REQ-025 HOLD, BranchTakenE=1: skid dropped, PCF<=BranchTargetE, go REQ.
REQ-026 HOLD, StallF=0: IF/ID loads from skid, PCF<=PCF+4, go REQ.
REQ-027 DISCARD: imem_valid response ignored (never reaches IF/ID), go REQ next cycle.
REQ-028 BranchTakenE SHALL have priority over imem_valid and StallF for PCF update.
REQ-029 FlushD=1 SHALL load IF/ID with {NOP_INSTR, PCD unchanged, ValidD=0}, priority over load and StallF.
REQ-030 StallF=1 without FlushD SHALL hold IF/ID exactly.
REQ-031 In cycles where no load occurs and StallF=0, IF/ID SHALL load a bubble (ValidD=0, NOP_INSTR).
REQ-032 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-033 Fetch-to-decode latency SHALL be one cycle after the imem_valid edge (zero stall).

Reset
REQ-034 rst_n low SHALL asynchronously force: state=BOOT, PCF=RESET_PC, imem_req=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, skid cleared.
REQ-035 Reset mid-request SHALL abandon the outstanding request; the first response after reset is the one for RESET_PC.

Structure
REQ-036 Shared package SHALL hold FSM state enum, NOP_INSTR, and opcode constants (7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011) common with the control unit.
REQ-037 IF/ID register with flush/stall priority SHALL be one sub-module, if_id_reg.

Verification
REQ-038 Reset release, imem latency 1 -> imem_addr 0,4,8 on consecutive requests; InstrD 1 cycle after each valid, ValidD=1.
REQ-039 StallF=1 on cycle of imem_valid, held 3 cycles -> HOLD, PCF frozen, InstrD unchanged, skid word in InstrD 1 cycle after release.
REQ-040 BranchTakenE=1, target 32'h100, imem latency 3, during REQ -> DISCARD, stale word never in InstrD, next imem_addr=32'h100.
REQ-041 FlushD=1 with StallF=1 and imem_valid=1 -> InstrD=32'h0000_0013, ValidD=0, PCD unchanged.
REQ-042 PCF=32'hFFFF_FFFC fetch completes -> next imem_addr=0, PCPlus4D=0.
REQ-043 rst_n low while imem_req=1 -> all outputs at reset values same cycle, one BOOT cycle, first fetch at RESET_PC.
